fp_csr_unit: RTL

Owns the floating-point CSR state (`fflags`, `frm`, `fcsr`) beside the FPU. It sits directly downstream of the FPU top: it consumes the per-cycle `fflags` and writeback-accepted strobes and accumulates the exception flags. It also feeds the FPU's `dyn_rm` input, and serialises CSR accesses against in-flight FP instructions so reads and writes observe precise flag state.

---
 rtl/fpu_types.sv | 31 +++
 rtl/fp_csr_unit_inflight_counter.sv | 37 +++
 rtl/fp_csr_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fpu_types.sv
// Shared FPU types: rounding-mode/flag fields plus the FP CSR access encodings.
// Pure declarations; no timing or flow-control behaviour of its own.
package fpu_types;

  localparam int FFLAGS_W = 5;
  localparam int FRM_W    = 3;

  typedef logic [FFLAGS_W-1:0] fflags_t;
  typedef logic [FRM_W-1:0]    rm_t;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } fp_csr_op_t;

  typedef enum logic [1:0] {
    CSR_SEL_NONE   = 2'b00,
    CSR_SEL_FFLAGS = 2'b01,
    CSR_SEL_FRM    = 2'b10,
    CSR_SEL_FCSR   = 2'b11
  } fp_csr_sel_t;

  typedef enum logic [1:0] {
    CSR_IDLE  = 2'b00,
    CSR_DRAIN = 2'b01,
    CSR_EXEC  = 2'b10
  } fp_csr_state_t;

endpackage

// File: rtl/fp_csr_unit_inflight_counter.sv
// Counts FP instructions issued but not yet retired; zero/full are registered-state decodes.
// Up to two retires and one issue per cycle; no saturation, so callers must keep it in range.
module fp_inflight_counter #(
  parameter  int MAX_INFLIGHT = 16,
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec_a,
  input  logic i_dec_b,
  output logic o_zero,
  output logic o_full
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_underflow;

  always_comb begin
    w_count_nxt = r_count + CW'(i_inc) - CW'(i_dec_a) - CW'(i_dec_b);
    w_underflow = ({1'b0, r_count} + (CW+1)'(i_inc)) <
                  ((CW+1)'(i_dec_a) + (CW+1)'(i_dec_b));
  end

  always_ff @(posedge clk) begin
    if (!rst) r_count <= '0;
    else      r_count <= w_count_nxt;
  end

  assign o_zero = (r_count == '0);
  assign o_full = (r_count == CW'(MAX_INFLIGHT));

  // More retires than outstanding instructions means the FPU handshake is broken.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !w_underflow);

endmodule

// File: rtl/fp_csr_unit.sv
// FP CSR state (fflags/frm/fcsr) beside the FPU; CSR accesses drain in-flight ops, ack >= 2 cycles after req.
// Holds FP issue while an access is pending. FS-dirty tracking is built only with FP_CSR_FS_DIRTY_EN.
module fp_csr_unit
  import fpu_types::*;
#(
  parameter int MAX_INFLIGHT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fp_issue,
  input  logic        fp_wb_accepted,
  input  logic        int_wb_accepted,
  input  logic [4:0]  fflags_in,
  input  logic        csr_req,
  input  logic [1:0]  csr_op,
  input  logic [1:0]  csr_sel,
  input  logic [7:0]  csr_wdata,
  output logic        csr_ack,
  output logic [31:0] csr_rdata,
  output logic [2:0]  dyn_rm,
  output logic        dyn_rm_invalid,
  output logic        issue_hold,
  output logic        fs_dirty,
  input  logic        fs_clean
);

  fp_csr_state_t r_state, w_state_nxt;
  fflags_t       r_fflags, w_flags_new;
  rm_t           r_frm, w_frm_new, w_frm_opnd;
  fp_csr_op_t    w_op;
  fp_csr_sel_t   w_sel;
  logic          w_wb, w_zero, w_full, w_exec, w_wr, w_wr_flags, w_wr_frm;
  logic [31:0]   w_old;

  assign w_op  = fp_csr_op_t'(csr_op);
  assign w_sel = fp_csr_sel_t'(csr_sel);
  assign w_wb  = fp_wb_accepted | int_wb_accepted;

  fp_inflight_counter #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (fp_issue),
    .i_dec_a (fp_wb_accepted),
    .i_dec_b (int_wb_accepted),
    .o_zero  (w_zero),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= CSR_IDLE;
    else      r_state <= w_state_nxt;
  end

  // A writeback in the check cycle could still change fflags, so it defers EXEC.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CSR_IDLE:  if (csr_req) w_state_nxt = CSR_DRAIN;
      CSR_DRAIN: if (w_zero && !w_wb) w_state_nxt = CSR_EXEC;
      CSR_EXEC:  w_state_nxt = CSR_IDLE;
      default:   w_state_nxt = CSR_IDLE;
    endcase
  end

  assign w_exec     = (r_state == CSR_EXEC);
  assign w_wr       = w_exec && (w_op != CSR_READ);
  assign w_wr_flags = w_wr && ((w_sel == CSR_SEL_FFLAGS) || (w_sel == CSR_SEL_FCSR));
  assign w_wr_frm   = w_wr && ((w_sel == CSR_SEL_FRM) || (w_sel == CSR_SEL_FCSR));

  always_comb begin
    w_old = '0;
    case (w_sel)
      CSR_SEL_FFLAGS: w_old = {27'b0, r_fflags};
      CSR_SEL_FRM:    w_old = {29'b0, r_frm};
      CSR_SEL_FCSR:   w_old = {24'b0, r_frm, r_fflags};
      default:        w_old = '0;
    endcase
  end

  // frm sits in the low bits when addressed alone, in [7:5] when addressed via fcsr.
  always_comb begin
    w_frm_opnd  = (w_sel == CSR_SEL_FRM) ? csr_wdata[2:0] : csr_wdata[7:5];
    w_flags_new = r_fflags;
    w_frm_new   = r_frm;
    case (w_op)
      CSR_WRITE: begin
        w_flags_new = csr_wdata[4:0];
        w_frm_new   = w_frm_opnd;
      end
      CSR_SET: begin
        w_flags_new = r_fflags | csr_wdata[4:0];
        w_frm_new   = r_frm | w_frm_opnd;
      end
      CSR_CLEAR: begin
        w_flags_new = r_fflags & ~csr_wdata[4:0];
        w_frm_new   = r_frm & ~w_frm_opnd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fflags <= '0;
      r_frm    <= '0;
    end else begin
      if (w_wr_flags)  r_fflags <= w_flags_new;
      else if (w_wb)   r_fflags <= r_fflags | fflags_in;
      if (w_wr_frm)    r_frm    <= w_frm_new;
    end
  end

  assign csr_ack        = w_exec;
  assign csr_rdata      = w_exec ? w_old : 32'h0;
  assign dyn_rm         = r_frm;
  assign dyn_rm_invalid = (r_frm >= 3'b101);
  assign issue_hold     = (r_state != CSR_IDLE) || w_full || csr_req;

`ifdef FP_CSR_FS_DIRTY_EN
  logic r_fs_dirty;
  always_ff @(posedge clk) begin
    if (!rst)             r_fs_dirty <= 1'b0;
    else if (w_wb | w_wr) r_fs_dirty <= 1'b1;
    else if (fs_clean)    r_fs_dirty <= 1'b0;
  end
  assign fs_dirty = r_fs_dirty;
`else
  logic w_unused_fs_clean;
  assign w_unused_fs_clean = fs_clean;
  assign fs_dirty          = 1'b0;
`endif

  a_no_issue_when_held: assert property (@(posedge clk) disable iff (!rst) !(fp_issue && issue_hold));

endmodule
